// File: rtl/fifo_pack_pkg.sv
// rtl/fifo_pack_pkg.sv - shared state encoding and count-width helper for the FIFO read packer
package fifo_pack_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } pack_state_t;

    // Bits needed to represent the values 0..value-1 (ceil(log2(value))).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_pack_outreg.sv
// rtl/fifo_pack_outreg.sv - output beat register holding data/count stable under backpressure
module fifo_pack_outreg #(
    parameter int DW = 64,
    parameter int CW = 2
) (
    input  logic          rclk,
    input  logic          rrst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [CW-1:0] load_count,
    input  logic          m_ready,
    output logic          slot_free,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic [CW-1:0] m_count
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] count_q, count_d;

    // Slot may be refilled when empty or when the held beat transfers on this edge.
    always_comb begin
        slot_free = !valid_q || m_ready;
        valid_d   = valid_q;
        data_d    = data_q;
        count_d   = count_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            count_d = load_count;
        end else if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end
    end

    // Beat register; data and count only change on a new load.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_count = count_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs RATIO FIFO words into one wide beat with flush and idle timeout
module fifo_rd_packer
    import fifo_pack_pkg::*;
#(
    parameter int DSIZE   = 32,
    parameter int RATIO   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                          rclk,
    input  logic                          rrst_n,
    input  logic                          rempty,
    input  logic [DSIZE-1:0]              rdata,
    output logic                          rinc,
    input  logic                          flush,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DSIZE*RATIO-1:0]        m_data,
    output logic [clog2(RATIO+1)-1:0]     m_count
);

    localparam int CW = clog2(RATIO + 1);
    localparam int W  = DSIZE * RATIO;

    pack_state_t state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [7:0]    idle_q, idle_d;
    logic [W-1:0]  data_q, data_d;

    logic          pop;
    logic [W-1:0]  acc;
    logic [CW-1:0] new_idx;
    logic          timeout_hit;
    logic          emit;
    logic          slot_free;
    logic          load;
    logic [W-1:0]  load_data;
    logic [CW-1:0] load_count;

    // Pop decision, lane insertion and group completion / partial emission.
    always_comb begin
        rinc = rrst_n && !rempty && (state_q != ST_FULL);
        pop  = rinc;

        acc = data_q;
        for (int k = 0; k < RATIO; k++) begin
            if (pop && (idx_q == CW'(k))) begin
                acc[k*DSIZE +: DSIZE] = rdata;
            end
        end
        new_idx     = idx_q + {{(CW-1){1'b0}}, pop};
        timeout_hit = (state_q == ST_FILL) && !pop && (idle_q == 8'(TIMEOUT - 1));
        // A completing pop wins over flush/timeout, so such a beat is always full.
        emit        = (new_idx == CW'(RATIO)) ||
                      ((new_idx != '0) && (flush || timeout_hit));

        state_d    = state_q;
        idx_d      = idx_q;
        idle_d     = idle_q;
        data_d     = data_q;
        load       = 1'b0;
        load_data  = acc;
        load_count = new_idx;

        if (state_q == ST_FULL) begin
            load_data  = data_q;
            load_count = idx_q;
            if (slot_free) begin
                load    = 1'b1;
                state_d = ST_EMPTY;
                idx_d   = '0;
                idle_d  = '0;
                data_d  = '0;
            end
        end else if (emit) begin
            if (slot_free) begin
                load    = 1'b1;
                state_d = ST_EMPTY;
                idx_d   = '0;
                idle_d  = '0;
                data_d  = '0;
            end else begin
                state_d = ST_FULL;
                idx_d   = new_idx;
                idle_d  = '0;
                data_d  = acc;
            end
        end else if (pop) begin
            state_d = ST_FILL;
            idx_d   = new_idx;
            idle_d  = '0;
            data_d  = acc;
        end else if (state_q == ST_FILL) begin
            idle_d = idle_q + 8'd1;
        end
    end

    // Packer state; reset discards any partially collected group.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            idle_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            data_q  <= data_d;
        end
    end

    fifo_pack_outreg #(
        .DW (W),
        .CW (CW)
    ) u_outreg (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .load       (load),
        .load_data  (load_data),
        .load_count (load_count),
        .m_ready    (m_ready),
        .slot_free  (slot_free),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_count    (m_count)
    );

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL have parameter DSIZE, default 32: FIFO read-data width in bits.
REQ-002 SHALL have parameter RATIO, default 2: FIFO words per output beat; legal range 2..16.
REQ-003 SHALL have parameter TIMEOUT, default 16: idle cycles before a partial beat is emitted; legal range 1..255.
REQ-004 SHALL have port rclk, input, 1: sole clock; one clock only; all state on its rising edge.
REQ-005 SHALL have port rrst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port rempty, input, 1: upstream first-word-fall-through FIFO is empty.
REQ-007 SHALL have port rdata, input, DSIZE: FIFO head word, valid while rempty=0.
REQ-008 SHALL have port rinc, output, 1: pops the FIFO head on this edge.
REQ-009 SHALL have port flush, input, 1: emit any partial group now.
REQ-010 SHALL have port m_valid, output, 1: output beat valid.
REQ-011 SHALL have port m_ready, input, 1: consumer accepts the beat.
REQ-012 SHALL have port m_data, output, DSIZE*RATIO: packed beat.
REQ-013 SHALL have port m_count, output, clog2(RATIO+1): number of valid words in m_data.

Function
REQ-014 SHALL pack little-endian: the first popped word of a group goes to m_data[DSIZE-1:0], the k-th word to lane k-1.
REQ-015 SHALL drive rinc combinationally as !rempty && (state!=FULL), and SHALL NOT assert rinc while rempty=1.
REQ-016 SHALL implement states as follows: EMPTY (idx=0), FILL (0<idx<RATIO), FULL (RATIO words held, output slot occupied).
REQ-017 SHALL, on a pop that completes a group, load the output register on that edge if the slot is free or accepted (m_valid=0 or m_ready=1); m_valid SHALL rise the next cycle (1-cycle latency), and the state SHALL return to EMPTY.
REQ-018 SHALL, if the slot is still held when a group completes, enter FULL, stop popping, and transfer on the first edge with m_ready=1.
REQ-019 SHALL hold m_data and m_count stable while m_valid=1 and m_ready=0.
REQ-020 SHALL count a beat as transferred on an edge where m_valid=1 and m_ready=1; back-to-back beats with no bubble SHALL be sustained when m_ready=1 and the FIFO is not empty.
REQ-021 SHALL run an idle counter in FILL that increments on each cycle with no pop and clears on a pop; on reaching TIMEOUT it SHALL emit the partial group, with m_count=idx and unfilled lanes zero.
REQ-022 SHALL, on flush=1 in FILL, emit the partial group the same way; a word popped on the flush edge SHALL be included.
REQ-023 SHALL ignore flush in EMPTY, so that no zero-count beat is ever emitted.
REQ-024 SHALL treat a flush or timeout while the output slot is occupied as pending: popping halts and the partial group is emitted when the slot frees.
REQ-025 SHALL handle a pop that reaches RATIO words on the same edge as a flush or timeout as a normal full beat with m_count=RATIO.
REQ-026 SHALL drive m_count=RATIO for full beats.

Reset
REQ-027 SHALL, while rrst_n=0, asynchronously force state EMPTY, idx=0, idle counter 0, m_valid=0, m_data=0 and m_count=0; rinc SHALL be 0 during reset.
REQ-028 SHALL discard any partial group and any held beat on reset mid-operation; no beat SHALL appear until after the first post-reset pop.

Structure
REQ-029 SHALL place the state enum and a count-width function clog2(RATIO+1) in shared package fifo_pack_pkg.
REQ-030 SHALL implement the output register with its valid/ready hold as sub-module fifo_pack_outreg.
REQ-031 SHALL provide each output from either combinational pop logic (rinc) or a register.

Verification (DSIZE=32, RATIO=2, TIMEOUT=16)
REQ-032 SHALL verify basic packing: FIFO holds 0xA, 0xB; m_ready=1 -> one beat with m_data=0x0000000B_0000000A, m_count=2, m_valid one cycle after the second pop.
REQ-033 SHALL verify streaming with backpressure: push 0..15 with m_ready=0 for 20 cycles, then m_ready=1 -> 8 beats in order (lane0=2n, lane1=2n+1); rinc=0 while FULL; beats hold stable while stalled.
REQ-034 SHALL verify timeout: single word 0x5 then FIFO empty -> after 16 idle cycles one beat with m_data=0x00000000_00000005 and m_count=1.
REQ-035 SHALL verify flush: flush=1 on the same edge as the pop of 0x7 from EMPTY -> beat with m_count=1 and lane0=0x7; flush in EMPTY -> no beat.
REQ-036 SHALL verify the flush/complete collision: pop of the second word with flush=1 -> m_count=2 and no extra beat.
REQ-037 SHALL verify reset mid-operation: assert rrst_n=0 with one partial word and one held beat -> m_valid=0 immediately; after release, words 0x1, 0x2 yield exactly one beat 0x2_0x1.
